spi_txn_arbiter: RTL and testbench
==================================

# spi_txn_arbiter

Shares one SPI bus (SCK/SSB/MOSI/MISO) among NREQ on-chip requesters. Each requester submits a two-byte transaction: a command byte followed by a data byte, the framing the SPI slave expects. The block round-robin arbitrates between requesters, generates SCK from the system clock, serialises both bytes MSB-first, and captures the MISO byte returned during the data byte. It sits between the system-side register/control logic and the SPI pins.

## Interface
- NREQ, 2, number of requesters (2..4)
- CLK_DIV, 4, system clocks per SCK half-period (≥2)
- clk  in  1  system clock; all logic on posedge
- reset  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester transaction request, level
- req_cmd  in  8*NREQ  command byte, requester i at [8i+7:8i]
- req_data  in  8*NREQ  data byte, same packing
- gnt  out  NREQ  one-hot, 1-cycle pulse: requester's cmd/data latched this cycle
- done  out  NREQ  one-hot, 1-cycle pulse: granted transaction complete
- rdata  out  8  MISO byte captured during data byte of last completed transaction
- busy  out  1  high whenever state ≠ IDLE
- SCK  out  1  SPI clock, idles low
- SSB  out  1  slave select, active-low, idles high
- MOSI  out  1  serial data to slave
- MISO  in  1  serial data from slave

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE: if any req bit is high, choose the winner round-robin. The search starts at (last_granted+1) mod NREQ. Assert gnt[winner] this cycle, latch {req_cmd, req_data} of the winner into a 16-bit shift register, record the winner, and go to SETUP. If no req bit is high, stay in IDLE.
- SETUP: lasts CLK_DIV cycles. SSB=0, SCK=0, MOSI=cmd[7]. Then go to SHIFT.
- SHIFT: 16 bits, each lasting 2*CLK_DIV cycles. Each bit is CLK_DIV cycles with SCK=0 followed by CLK_DIV cycles with SCK=1.
  - MOSI holds the current bit for the whole bit period.
  - Bit order: cmd[7..0], then data[7..0].
  - Sample MISO in the cycle SCK rises. Only bits 8..15 (data byte) are shifted into the rx register, MSB first.
  - After bit 15, go to HOLD.
- HOLD: lasts CLK_DIV cycles. SSB=0, SCK=0, MOSI=0. Then go to GAP.
- GAP: lasts 2*CLK_DIV cycles. SSB=1, SCK=0, MOSI=0.
  - In the last GAP cycle, pulse done[winner] and update rdata from the rx register.
  - Then go to IDLE.
- rdata holds its value until the next done. Its value is undefined (held) during a transaction.
- A requester dropping req before being granted is simply not considered. req and cmd/data changes after gnt have no effect on the current transaction.
- A requester whose req is still high at its done is eligible again. Round-robin guarantees other pending requesters are served first.
- Counters:
  - Divider counter: width ceil(log2(2*CLK_DIV))+1, wraps to 0 at each phase end.
  - Bit counter: 5 bits, 0..15.
  - No arithmetic overflow is permitted.

## Timing
- All outputs are registered. An output change corresponding to entering a state is visible in that state's first cycle.
- gnt occurs in cycle 0, which is an IDLE cycle.
  - SSB falls in cycle 1.
  - First SCK rise in cycle CLK_DIV+CLK_DIV+1.
  - SSB rises in cycle 34*CLK_DIV+1.
  - done and rdata update in cycle 36*CLK_DIV.
  - IDLE in cycle 36*CLK_DIV+1.
- Back-to-back: the earliest next gnt is in cycle 36*CLK_DIV+1, so the transaction period is 36*CLK_DIV+1 cycles.
- Reset values:
  - Outputs: SSB=1, SCK=0, MOSI=0, gnt=0, done=0, busy=0, rdata=8'h00.
  - State and counters: state=IDLE, counters 0.
  - last_granted=NREQ-1, so requester 0 wins the first arbitration.
- Reset mid-transaction: in the next cycle SSB=1, SCK=0, MOSI=0, busy=0. No done pulse is produced. The aborted transaction is lost.
- Simultaneous requests in IDLE: exactly one gnt bit is set, per round-robin. gnt and done are never asserted in the same cycle.

## Test plan
- CLK_DIV=2, NREQ=2. req[0] with cmd=8'h01, data=8'hA5; slave returns 8'h3C. Expect:
  - gnt[0] at cycle 0.
  - MOSI sequence 0000_0001_1010_0101 sampled on SCK rises.
  - 16 SCK pulses.
  - done[0] at cycle 72 with rdata=8'h3C.
  - busy low at cycle 73.
- Both req high continuously from reset. Expect:
  - Grants alternate 0,1,0,1.
  - Successive gnt pulses are 73 cycles apart.
  - Never two gnt bits high at once.
- req[1] pulsed for 1 cycle during a requester-0 transaction, then dropped. Expect no gnt[1] and a return to IDLE after done[0].
- Reset asserted at cycle 30 of a transaction. Expect:
  - Cycle 31: SSB=1, SCK=0, MOSI=0, busy=0.
  - No done.
  - The next req[0] gets gnt[0] and completes normally.
- CLK_DIV=4. Expect:
  - SCK high and low phases exactly 4 cycles each.
  - SSB low for 136 cycles.
  - done at cycle 144.
- req_data changed in the cycle after gnt. Expect the originally latched byte on MOSI.

Source files
------------

// File: rtl/spi_txn_arbiter_if.sv
// Bus bundle between the SPI transaction arbiter and its requesters.
// Ports: req/req_cmd/req_data/MISO in; gnt/done/rdata/busy/SCK/SSB/MOSI out.
interface spi_txn_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_cmd;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [7:0]        rdata;
    logic              busy;
    logic              SCK;
    logic              SSB;
    logic              MOSI;
    logic              MISO;

    modport master (
        output req, req_cmd, req_data, MISO,
        input  gnt, done, rdata, busy, SCK, SSB, MOSI
    );

    modport slave (
        input  req, req_cmd, req_data, MISO,
        output gnt, done, rdata, busy, SCK, SSB, MOSI
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI bus; sends cmd+data bytes MSB-first.
// Ports: clk, reset (sync, active-high), bus (slave modport of the bus bundle).
module spi_txn_arbiter #(
    parameter int NREQ    = 2,
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               reset,
    spi_txn_arbiter_if.slave   bus
);
    localparam int CW = $clog2(2 * CLK_DIV) + 1;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [CW-1:0] PH_END   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HI_FIRST = CW'(CLK_DIV);
    localparam logic [CW-1:0] BIT_END  = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_PRE  = CW'(2 * CLK_DIV - 2);
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      bit_q, bit_d;
    logic [15:0]     sr_q, sr_d;
    logic [7:0]      rx_q, rx_d;
    logic [IW-1:0]   last_q, last_d;
    logic            sck_q, sck_d;
    logic            ssb_q, ssb_d;
    logic            mosi_q, mosi_d;
    logic            busy_q, busy_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [NREQ-1:0] gnt_c;

    logic [IW-1:0]   win;
    logic [IW-1:0]   cand;
    logic            any;
    logic [7:0]      cmd_sel;
    logic [7:0]      data_sel;

    // Round-robin search starting just after the last winner.
    always_comb begin
        win      = last_q;
        any      = 1'b0;
        cand     = '0;
        cmd_sel  = '0;
        data_sel = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_q) + k) % NREQ);
            if (!any && bus.req[cand]) begin
                any = 1'b1;
                win = cand;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) begin
                cmd_sel  = bus.req_cmd[8*i +: 8];
                data_sel = bus.req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            rx_q    <= '0;
            last_q  <= LAST_RST;
            sck_q   <= 1'b0;
            ssb_q   <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            rx_q    <= rx_d;
            last_q  <= last_d;
            sck_q   <= sck_d;
            ssb_q   <= ssb_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic; pin outputs are computed one cycle ahead so the
    // registered value lands in the first cycle of the new state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        sr_d    = sr_q;
        rx_d    = rx_q;
        last_d  = last_q;
        sck_d   = sck_q;
        ssb_d   = ssb_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = '0;
        rdata_d = rdata_q;
        gnt_c   = '0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (any && !reset) begin
                    gnt_c[win] = 1'b1;
                    last_d     = win;
                    sr_d       = {cmd_sel, data_sel};
                    state_d    = SETUP;
                    ssb_d      = 1'b0;
                    sck_d      = 1'b0;
                    mosi_d     = cmd_sel[7];
                    busy_d     = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == PH_END) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == PH_END) begin
                    sck_d = 1'b1;
                end
                // Capture in the first SCK-high cycle, data byte only.
                if (cnt_q == HI_FIRST && bit_q[3]) begin
                    rx_d = {rx_q[6:0], bus.MISO};
                end
                if (cnt_q == BIT_END) begin
                    cnt_d = '0;
                    sck_d = 1'b0;
                    if (bit_q == 5'd15) begin
                        state_d = HOLD;
                        mosi_d  = 1'b0;
                    end else begin
                        bit_d  = bit_q + 5'd1;
                        sr_d   = {sr_q[14:0], 1'b0};
                        mosi_d = sr_q[14];
                    end
                end
            end
            HOLD: begin
                if (cnt_q == PH_END) begin
                    cnt_d   = '0;
                    state_d = GAP;
                    ssb_d   = 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_PRE) begin
                    done_d[last_q] = 1'b1;
                    rdata_d        = rx_q;
                end
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.gnt   = gnt_c;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign bus.SCK   = sck_q;
    assign bus.SSB   = ssb_q;
    assign bus.MOSI  = mosi_q;
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: vector table, corner sequences, random traffic.
// A timeline model predicts every pin per cycle from the transaction start.
module tb_spi_txn_arbiter;
    localparam int N   = 2;
    localparam int CD  = 2;
    localparam int PER = 36 * CD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic reset4;

    spi_txn_arbiter_if #(.NREQ(N)) bif ();
    spi_txn_arbiter_if #(.NREQ(N)) bif4 ();

    spi_txn_arbiter #(.NREQ(N), .CLK_DIV(CD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    spi_txn_arbiter #(.NREQ(N), .CLK_DIV(4)) dut4 (
        .clk   (clk),
        .reset (reset4),
        .bus   (bif4)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic rst_prev = 1'b1;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= reset;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int rr(input int last, input logic [N-1:0] r);
        logic [N-1:0] sh;
        for (int k = 1; k <= N; k++) begin
            int j;
            j  = (last + k) % N;
            sh = r >> j;
            if (sh[0]) return j;
        end
        return last;
    endfunction

    // Reference model state
    bit          chk_en = 1'b0;
    bit          use_fixed = 1'b1;
    logic [7:0]  fixed_sb = 8'h00;
    bit          m_valid = 1'b0;
    int          m_free = 0;
    int          m_gnt_at = 0;
    int          m_last = N - 1;
    logic [15:0] m_bits = 16'h0;
    logic [7:0]  m_sb = 8'h00;
    logic [7:0]  m_rdata = 8'h00;
    logic [N-1:0] eg, ed;
    int          md, mo, mw;
    logic        es, ek, em;
    logic [15:0] mtmp;

    // Slave / monitor state
    int          sfalls = 0;
    logic        sck_prev = 1'b0;
    logic        ssb_prev = 1'b1;
    logic [15:0] mon_bits = 16'h0;
    int          mon_rises = 0;
    logic [7:0]  sbv;

    always @(negedge clk) begin
        if (chk_en) begin
            eg = '0;
            ed = '0;
            if (rst_prev) begin
                m_valid = 1'b0;
                m_free  = cyc;
                m_last  = N - 1;
                m_rdata = 8'h00;
            end
            if (!reset && cyc >= m_free && bif.req != '0) begin
                mw       = rr(m_last, bif.req);
                eg       = N'(1) << mw;
                m_last   = mw;
                m_valid  = 1'b1;
                m_gnt_at = cyc;
                m_free   = cyc + PER + 1;
                m_bits   = (mw == 1) ?
                           {bif.req_cmd[15:8], bif.req_data[15:8]} :
                           {bif.req_cmd[7:0], bif.req_data[7:0]};
                m_sb     = use_fixed ? fixed_sb : 8'($urandom);
            end
            md = cyc - m_gnt_at;
            mo = md - 1 - CD;
            if (m_valid && md == PER) begin
                ed      = N'(1) << m_last;
                m_rdata = m_sb;
            end
            es = !(m_valid && md >= 1 && md <= 34 * CD);
            ek = m_valid && mo >= 0 && mo < 32 * CD && (mo % (2 * CD)) >= CD;
            mtmp = m_bits << (mo / (2 * CD));
            if (m_valid && md >= 1 && md <= CD)
                em = m_bits[15];
            else if (m_valid && mo >= 0 && mo < 32 * CD)
                em = mtmp[15];
            else
                em = 1'b0;
            chk("gnt",   32'(bif.gnt),   32'(eg));
            chk("done",  32'(bif.done),  32'(ed));
            chk("busy",  32'(bif.busy),
                32'(m_valid && md >= 1 && md <= PER));
            chk("ssb",   32'(bif.SSB),   32'(es));
            chk("sck",   32'(bif.SCK),   32'(ek));
            chk("mosi",  32'(bif.MOSI),  32'(em));
            chk("rdata", 32'(bif.rdata), 32'(m_rdata));
        end
        // SPI slave: returns m_sb during the data byte, shifts on SCK fall.
        if (bif.SSB)
            sfalls = 0;
        else if (sck_prev && !bif.SCK)
            sfalls++;
        if (ssb_prev && !bif.SSB) begin
            mon_bits  = 16'h0;
            mon_rises = 0;
        end
        if (!sck_prev && bif.SCK) begin
            mon_bits  = {mon_bits[14:0], bif.MOSI};
            mon_rises++;
        end
        sbv      = m_sb << (sfalls - 8);
        bif.MISO = (!bif.SSB && sfalls >= 8 && sfalls < 16) ? sbv[7] : 1'b0;
        sck_prev = bif.SCK;
        ssb_prev = bif.SSB;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output int at, output logic [N-1:0] g);
        at = -1;
        g  = '0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bif.gnt != '0) begin
                at = cyc;
                g  = bif.gnt;
                break;
            end
        end
        if (at < 0) chk("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(output int at, output logic [N-1:0] dn);
        at = -1;
        dn = '0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bif.done != '0) begin
                at = cyc;
                dn = bif.done;
                break;
            end
        end
        if (at < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [7:0]   c0, d0, c1, d1, sb;
        logic [N-1:0] egnt;
        logic [15:0]  emosi;
    } vec_t;

    vec_t         tbl[5];
    int           at, at2, ng, nd, viol, rises, first_rise, ssb_lo;
    int           done_at4;
    int           ga[4];
    logic [N-1:0] g, dn;
    logic [N-1:0] gg[4];
    logic         sk4[160];
    logic         ssb4[160];
    logic [N-1:0] dn4[160];
    logic [7:0]   rd4[160];

    initial begin
        reset         = 1'b1;
        reset4        = 1'b1;
        bif.req       = '0;
        bif.req_cmd   = '0;
        bif.req_data  = '0;
        bif4.req      = '0;
        bif4.req_cmd  = '0;
        bif4.req_data = '0;
        bif4.MISO     = 1'b1;

        tbl[0] = '{2'b01, 8'h01, 8'hA5, 8'h00, 8'h00, 8'h3C, 2'b01, 16'h01A5};
        tbl[1] = '{2'b11, 8'h11, 8'h22, 8'h9A, 8'h5F, 8'hC3, 2'b10, 16'h9A5F};
        tbl[2] = '{2'b11, 8'hFF, 8'h00, 8'h12, 8'h34, 8'h81, 2'b01, 16'hFF00};
        tbl[3] = '{2'b01, 8'h80, 8'h01, 8'h77, 8'h66, 8'h00, 2'b01, 16'h8001};
        tbl[4] = '{2'b10, 8'h00, 8'h00, 8'hC0, 8'hDE, 8'hFF, 2'b10, 16'hC0DE};

        @(posedge clk);
        #1 chk_en = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        reset4 = 1'b0;
        @(negedge clk);
        chk("rst_ssb",   32'(bif.SSB),   32'd1);
        chk("rst_sck",   32'(bif.SCK),   32'd0);
        chk("rst_mosi",  32'(bif.MOSI),  32'd0);
        chk("rst_busy",  32'(bif.busy),  32'd0);
        chk("rst_rdata", 32'(bif.rdata), 32'd0);
        chk("rst_done",  32'(bif.done),  32'd0);

        // Vector table; data is scrambled right after each grant.
        for (int i = 0; i < 5; i++) begin
            tick();
            bif.req      = tbl[i].req;
            bif.req_cmd  = {tbl[i].c1, tbl[i].c0};
            bif.req_data = {tbl[i].d1, tbl[i].d0};
            fixed_sb     = tbl[i].sb;
            wait_gnt(at, g);
            chk("vec_gnt", 32'(g), 32'(tbl[i].egnt));
            tick();
            bif.req      = '0;
            bif.req_data = ~bif.req_data;
            wait_done(at2, dn);
            chk("vec_done",  32'(dn), 32'(tbl[i].egnt));
            chk("vec_lat",   32'(at2 - at), 32'(PER));
            chk("vec_rdata", 32'(bif.rdata), 32'(tbl[i].sb));
            chk("vec_mosi",  32'(mon_bits), 32'(tbl[i].emosi));
            chk("vec_sck_n", 32'(mon_rises), 32'd16);
            @(negedge clk);
            chk("vec_idle",  32'(bif.busy), 32'd0);
        end

        // Both requesting continuously from reset.
        tick();
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        bif.req      = 2'b11;
        bif.req_cmd  = 16'h1234;
        bif.req_data = 16'h5678;
        fixed_sb     = 8'h99;
        for (int k = 0; k < 4; k++) wait_gnt(ga[k], gg[k]);
        tick();
        bif.req = '0;
        for (int k = 0; k < 4; k++) begin
            chk("rr_order", 32'(gg[k]), (k % 2 == 0) ? 32'd1 : 32'd2);
            if (k > 0) chk("rr_period", 32'(ga[k] - ga[k-1]), 32'(PER + 1));
        end
        wait_done(at2, dn);
        chk("rr_last_done", 32'(dn), 32'd2);

        // Short req[1] pulse while requester 0 is busy.
        tick();
        bif.req = 2'b01;
        wait_gnt(at, g);
        chk("pulse_gnt0", 32'(g), 32'd1);
        tick();
        bif.req = '0;
        tick();
        tick();
        bif.req = 2'b10;
        tick();
        bif.req = '0;
        ng = 0;
        nd = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bif.gnt != '0) ng++;
            if (bif.done == 2'b01) nd++;
        end
        chk("pulse_no_gnt", 32'(ng), 32'd0);
        chk("pulse_done",   32'(nd), 32'd1);
        chk("pulse_idle",   32'(bif.busy), 32'd0);

        // Reset in cycle 30 of a transaction.
        tick();
        bif.req = 2'b01;
        wait_gnt(at, g);
        tick();
        bif.req = '0;
        while (cyc < at + 30) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_ssb",  32'(bif.SSB),  32'd1);
        chk("mid_sck",  32'(bif.SCK),  32'd0);
        chk("mid_mosi", 32'(bif.MOSI), 32'd0);
        chk("mid_busy", 32'(bif.busy), 32'd0);
        nd = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (bif.done != '0) nd++;
        end
        chk("mid_no_done", 32'(nd), 32'd0);
        tick();
        bif.req  = 2'b01;
        fixed_sb = 8'h5A;
        wait_gnt(at, g);
        chk("mid_regnt", 32'(g), 32'd1);
        tick();
        bif.req = '0;
        wait_done(at2, dn);
        chk("mid_redone",  32'(dn), 32'd1);
        chk("mid_rerdata", 32'(bif.rdata), 32'h5A);

        // CLK_DIV=4 instance timing.
        tick();
        bif4.req      = 2'b01;
        bif4.req_cmd  = 16'h005A;
        bif4.req_data = 16'h00C3;
        ng = 0;
        for (int k = 0; k < 20 && ng == 0; k++) begin
            @(negedge clk);
            if (bif4.gnt != '0) ng = 1;
        end
        chk("cd4_gnt", 32'(bif4.gnt), 32'd1);
        for (int d = 0; d < 160; d++) begin
            if (d > 0) @(negedge clk);
            if (d == 1) bif4.req = '0;
            sk4[d]  = bif4.SCK;
            ssb4[d] = bif4.SSB;
            dn4[d]  = bif4.done;
            rd4[d]  = bif4.rdata;
        end
        viol = 0;
        rises = 0;
        first_rise = -1;
        ssb_lo = 0;
        done_at4 = -1;
        for (int d = 0; d < 160; d++) begin
            if (!ssb4[d]) ssb_lo++;
            if (dn4[d] != '0 && done_at4 < 0) done_at4 = d;
            if (d > 0 && sk4[d] && !sk4[d-1]) begin
                rises++;
                if (first_rise < 0) first_rise = d;
                for (int j = 0; j < 4; j++)
                    if (d + j < 160 && !sk4[d+j]) viol++;
                if (d + 4 < 160 && sk4[d+4]) viol++;
                if (rises > 1) begin
                    for (int j = 1; j <= 4; j++)
                        if (sk4[d-j]) viol++;
                    if (!sk4[d-5]) viol++;
                end
            end
        end
        chk("cd4_phase",   32'(viol), 32'd0);
        chk("cd4_rises",   32'(rises), 32'd16);
        chk("cd4_first",   32'(first_rise), 32'd9);
        chk("cd4_ssb_lo",  32'(ssb_lo), 32'd136);
        chk("cd4_done_at", 32'(done_at4), 32'd144);
        if (done_at4 >= 0) begin
            chk("cd4_done",  32'(dn4[done_at4]), 32'd1);
            chk("cd4_rdata", 32'(rd4[done_at4]), 32'hFF);
        end

        // Random traffic against the timeline model.
        use_fixed = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if ($urandom % 4 == 0) bif.req = N'($urandom);
            bif.req_cmd  = 16'($urandom);
            bif.req_data = 16'($urandom);
            reset = ($urandom % 700 == 0);
        end
        tick();
        reset   = 1'b0;
        bif.req = '0;
        repeat (200) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
